run_ctrl_watchdog: RTL and testbench
====================================

Name: run_ctrl_watchdog

Overview:
- Synthesizable run controller and watchdog for the CPU test harness.
- Sequences DUT reset and counts run cycles.
- Detects halt across N monitor channels and watches for a global timeout and for commit-progress stalls.
- Drains for a cause-specific number of cycles after an error, then raises a single finish with a latched status code for the bench or an FPGA host to act on.

Parameters:
- CHANNELS, 8, number of halt/commit monitor channels
- RST_CYCLES, 2, cycles dut_rst is held high after rst deasserts (min 1)
- TIMEOUT, 10000000, RUN-cycle limit; 0 disables the timeout
- STALL_LIMIT, 4096, consecutive RUN cycles with no commit before a stall fires; 0 disables
- HALT_ALL, 0, 0 = finish when any channel halts; 1 = finish only after every channel has halted (sticky per channel)
- MON_DRAIN, 15, drain cycles after a monitor error
- MEM_DRAIN, 5, drain cycles after a memory-model error
- CW, 32, cycle counter width

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- halt, in, CHANNELS, per-channel halt indication (level)
- commit, in, CHANNELS, per-channel retire valid; any bit set counts as progress
- mon_error, in, 1, monitor error flag
- mem_error, in, 1, memory-model error flag
- dut_rst, out, 1, synchronous reset to DUT
- running, out, 1, high in RUN state
- finish, out, 1, one-cycle pulse on entry to DONE
- done, out, 1, level, high in DONE
- status, out, 3, latched termination cause
- cycles, out, CW, RUN cycle count, saturating
- halted_mask, out, CHANNELS, sticky record of channels that have halted

Behaviour:
- Reset values (async on rst): state=RST_SEQ, dut_rst=1, running=0, finish=0, done=0, status=0, cycles=0, halted_mask=0, all internal counters=0.
- States:
  - RST_SEQ: hold dut_rst=1 for exactly RST_CYCLES clocks after rst falls, then go to RUN with dut_rst=0 on the same edge. Inputs are ignored in RST_SEQ.
  - RUN: cycles increments each cycle and saturates at all-ones. halted_mask |= halt each cycle. The stall counter clears on any commit bit, otherwise increments.
  - DRAIN: a countdown loaded with the drain length for the cause. Go to DONE when it reaches 0.
  - DONE: terminal. finish pulses on the entry cycle only. done stays high until rst.
- Status codes: 0 none, 1 halt, 2 timeout, 3 stall, 4 mon_error, 5 mem_error.
- Termination conditions, evaluated each RUN cycle using current-cycle inputs:
  - halt_hit = HALT_ALL ? &(halted_mask | halt) : |halt
  - timeout_hit = TIMEOUT!=0 && cycles==TIMEOUT-1
  - stall_hit = STALL_LIMIT!=0 && no commit this cycle && stall_cnt==STALL_LIMIT-1
- Simultaneous causes use fixed priority: mem_error > mon_error > halt > timeout > stall. Only the winner is latched into status.
- Routing by cause:
  - halt, timeout, stall: go directly to DONE on the next edge (zero drain).
  - mon_error: go to DRAIN with MON_DRAIN. If MON_DRAIN=0, go directly to DONE.
  - mem_error: go to DRAIN with MEM_DRAIN. If MEM_DRAIN=0, go directly to DONE.
- The first cause wins. Any further events in DRAIN (including a higher-priority error) change neither status nor the drain length.
- cycles and halted_mask freeze on leaving RUN.
- Latency: a cause sampled at edge N gives finish at edge N+1 (zero drain) or at edge N+1+D (drain D).
- Reset mid-RUN or mid-DRAIN immediately (asynchronously) restores the reset values, and the reset sequence restarts.
- With HALT_ALL=1, a channel that halts then drops halt stays marked.

Test Plan:
- Reset sequence: rst high 3 cycles then low, RST_CYCLES=2 -> dut_rst falls exactly 2 edges after rst falls; running rises the same edge; cycles=0 at that edge.
- Any-halt: CHANNELS=8, HALT_ALL=0, halt=8'h04 at RUN cycle 100 -> finish pulse next edge, status=1, cycles=101, halted_mask=8'h04, done stays high.
- All-halt: HALT_ALL=1; channels halt one at a time, each dropping halt afterwards; the last channel halts at cycle 50 -> finish only then, status=1, halted_mask=8'hFF.
- Timeout vs stall: TIMEOUT=1000, STALL_LIMIT=0, commit toggling -> status=2 with cycles=1000. Second run: STALL_LIMIT=16, commit held 0 after cycle 20 -> status=3 at cycle 36.
- Error drain and priority: mon_error and halt asserted in the same cycle -> status=4 and finish exactly 16 edges later. mem_error pulsed during that drain -> status stays 4 and the drain is not reloaded. Separate run: mem_error alone -> status=5 and finish 6 edges later.
- Async reset in DRAIN: rst asserted mid-clock during DRAIN -> all outputs take reset values before the next edge, and the sequence restarts cleanly.

Source files
------------

// File: rtl/run_ctrl_watchdog.sv
// rtl/run_ctrl_watchdog.sv - run controller and watchdog for the CPU test harness
// Sequences DUT reset, counts run cycles, detects halt/timeout/stall/errors, drains, then finishes.
module run_ctrl_watchdog #(
   parameter int CHANNELS    = 8,
   parameter int RST_CYCLES  = 2,
   parameter int TIMEOUT     = 10000000,
   parameter int STALL_LIMIT = 4096,
   parameter int HALT_ALL    = 0,
   parameter int MON_DRAIN   = 15,
   parameter int MEM_DRAIN   = 5,
   parameter int CW          = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] halt,
   input  logic [CHANNELS-1:0] commit,
   input  logic                mon_error,
   input  logic                mem_error,
   output logic                dut_rst,
   output logic                running,
   output logic                finish,
   output logic                done,
   output logic [2:0]          status,
   output logic [CW-1:0]       cycles,
   output logic [CHANNELS-1:0] halted_mask
);

   localparam int RW   = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
   localparam int SW   = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
   localparam int DMAX = (MON_DRAIN > MEM_DRAIN) ? MON_DRAIN : MEM_DRAIN;
   localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;

   localparam logic [2:0] ST_NONE    = 3'd0;
   localparam logic [2:0] ST_HALT    = 3'd1;
   localparam logic [2:0] ST_TIMEOUT = 3'd2;
   localparam logic [2:0] ST_STALL   = 3'd3;
   localparam logic [2:0] ST_MON     = 3'd4;
   localparam logic [2:0] ST_MEM     = 3'd5;

   typedef enum logic [1:0] {
      S_RST_SEQ,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
   logic [CW-1:0]         cycles_q, cycles_d;
   logic [CHANNELS-1:0]   mask_q, mask_d;
   logic [SW-1:0]         stall_q, stall_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic [2:0]            status_q, status_d;
   logic                  finish_q, finish_d;
   logic                  dut_rst_q, dut_rst_d;

   logic                  halt_hit, timeout_hit, stall_hit, any_commit;
   logic [2:0]            cause;
   logic [DW-1:0]         drain_len;

   assign any_commit  = |commit;
   assign halt_hit    = (HALT_ALL != 0) ? (&(mask_q | halt)) : (|halt);
   assign timeout_hit = (TIMEOUT != 0) && (cycles_q == CW'(TIMEOUT - 1));
   assign stall_hit   = (STALL_LIMIT != 0) && !any_commit && (stall_q == SW'(STALL_LIMIT - 1));

   // Fixed priority: only the highest-ranked cause this cycle is latched.
   always_comb begin
      cause     = ST_NONE;
      drain_len = '0;
      if (mem_error) begin
         cause     = ST_MEM;
         drain_len = DW'(MEM_DRAIN);
      end else if (mon_error) begin
         cause     = ST_MON;
         drain_len = DW'(MON_DRAIN);
      end else if (halt_hit) begin
         cause = ST_HALT;
      end else if (timeout_hit) begin
         cause = ST_TIMEOUT;
      end else if (stall_hit) begin
         cause = ST_STALL;
      end
   end

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycles_d  = cycles_q;
      mask_d    = mask_q;
      stall_d   = stall_q;
      drain_d   = drain_q;
      status_d  = status_q;
      finish_d  = 1'b0;
      dut_rst_d = dut_rst_q;
      case (state_q)
         S_RST_SEQ: begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
               state_d   = S_RUN;
               dut_rst_d = 1'b0;
            end
         end
         S_RUN: begin
            cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
            mask_d   = mask_q | halt;
            stall_d  = any_commit ? '0 : stall_q + 1'b1;
            if (cause != ST_NONE) begin
               status_d = cause;
               if (drain_len == '0) begin
                  state_d  = S_DONE;
                  finish_d = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = drain_len;
               end
            end
         end
         S_DRAIN: begin
            // Later events are ignored here; the first cause owns status and drain length.
            drain_d = drain_q - 1'b1;
            if (drain_q <= DW'(1)) begin
               state_d  = S_DONE;
               finish_d = 1'b1;
            end
         end
         S_DONE: begin
         end
         default: begin
            state_d = S_RST_SEQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RST_SEQ;
         rst_cnt_q <= '0;
         cycles_q  <= '0;
         mask_q    <= '0;
         stall_q   <= '0;
         drain_q   <= '0;
         status_q  <= ST_NONE;
         finish_q  <= 1'b0;
         dut_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cycles_q  <= cycles_d;
         mask_q    <= mask_d;
         stall_q   <= stall_d;
         drain_q   <= drain_d;
         status_q  <= status_d;
         finish_q  <= finish_d;
         dut_rst_q <= dut_rst_d;
      end
   end

   assign dut_rst     = dut_rst_q;
   assign running     = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign finish      = finish_q;
   assign status      = status_q;
   assign cycles      = cycles_q;
   assign halted_mask = mask_q;

endmodule

// File: tb/tb_run_ctrl_watchdog.sv
// tb/tb_run_ctrl_watchdog.sv - scoreboard bench for run_ctrl_watchdog
// Two instances (any-halt with stall watchdog, all-halt without) share stimulus.
module tb_run_ctrl_watchdog;
   localparam int CH    = 8;
   localparam int LEN   = 1100;
   localparam int TMO   = 1000;
   localparam int MON_D = 15;
   localparam int MEM_D = 5;
   localparam int RUNS  = 25;

   typedef struct {
      int fin;
      int status;
      int cyc;
      logic [CH-1:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CH-1:0] halt = '0;
   logic [CH-1:0] commit = '0;
   logic mon_error = 1'b0;
   logic mem_error = 1'b0;

   logic dut_rst_a, running_a, finish_a, done_a;
   logic [2:0] status_a;
   logic [31:0] cycles_a;
   logic [CH-1:0] mask_a;
   logic dut_rst_b, running_b, finish_b, done_b;
   logic [2:0] status_b;
   logic [31:0] cycles_b;
   logic [CH-1:0] mask_b;

   logic [CH-1:0] halt_v [LEN];
   logic [CH-1:0] commit_v [LEN];
   logic mon_v [LEN];
   logic mem_v [LEN];

   exp_t q0[$];
   exp_t q1[$];
   int vectors = 0;
   int miscompares = 0;
   int cur_c = -1;

   always #5 clk = ~clk;

   run_ctrl_watchdog #(.CHANNELS(CH), .RST_CYCLES(2), .TIMEOUT(TMO), .STALL_LIMIT(16),
                       .HALT_ALL(0), .MON_DRAIN(MON_D), .MEM_DRAIN(MEM_D), .CW(32)) u_a (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .mon_error(mon_error),
      .mem_error(mem_error), .dut_rst(dut_rst_a), .running(running_a), .finish(finish_a),
      .done(done_a), .status(status_a), .cycles(cycles_a), .halted_mask(mask_a));

   run_ctrl_watchdog #(.CHANNELS(CH), .RST_CYCLES(2), .TIMEOUT(TMO), .STALL_LIMIT(0),
                       .HALT_ALL(1), .MON_DRAIN(MON_D), .MEM_DRAIN(MEM_D), .CW(32)) u_b (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .mon_error(mon_error),
      .mem_error(mem_error), .dut_rst(dut_rst_b), .running(running_b), .finish(finish_b),
      .done(done_b), .status(status_b), .cycles(cycles_b), .halted_mask(mask_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk RUN cycles, find the first cycle with any cause, apply priority and drain.
   function automatic exp_t model(input bit halt_all, input int stall_limit);
      exp_t e;
      logic [CH-1:0] m;
      int zrun, st, drain;
      m = '0;
      zrun = 0;
      e.fin = -1;
      e.status = 0;
      e.cyc = 0;
      e.mask = '0;
      for (int c = 0; c < LEN; c++) begin
         st = 0;
         drain = 0;
         m = m | halt_v[c];
         zrun = (commit_v[c] == '0) ? zrun + 1 : 0;
         if (mem_v[c]) begin
            st = 5;
            drain = MEM_D;
         end else if (mon_v[c]) begin
            st = 4;
            drain = MON_D;
         end else if (halt_all ? (m == {CH{1'b1}}) : (halt_v[c] != '0)) st = 1;
         else if (c == TMO - 1) st = 2;
         else if (stall_limit != 0 && zrun == stall_limit) st = 3;
         if (st != 0) begin
            e.fin = c + 1 + drain;
            e.status = st;
            e.cyc = c + 1;
            e.mask = m;
            return e;
         end
      end
      return e;
   endfunction

   task automatic check_end(input int d, input exp_t e);
      string n;
      n = (d == 0) ? "a" : "b";
      chk($sformatf("%s finish cycle", n), 64'(cur_c), 64'(e.fin));
      chk($sformatf("%s status", n), (d == 0) ? 64'(status_a) : 64'(status_b), 64'(e.status));
      chk($sformatf("%s cycles", n), (d == 0) ? 64'(cycles_a) : 64'(cycles_b), 64'(e.cyc));
      chk($sformatf("%s halted_mask", n), (d == 0) ? 64'(mask_a) : 64'(mask_b), 64'(e.mask));
      chk($sformatf("%s done with finish", n), (d == 0) ? 64'(done_a) : 64'(done_b), 64'd1);
   endtask

   always @(negedge clk) begin
      if (!rst && cur_c >= 0) begin
         if (finish_a) begin
            if (q0.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL a unexpected finish: got finish=1 at cycle %0d expected none", cur_c);
            end else check_end(0, q0.pop_front());
         end
         if (finish_b) begin
            if (q1.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL b unexpected finish: got finish=1 at cycle %0d expected none", cur_c);
            end else check_end(1, q1.pop_front());
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, " a dut_rst"}, 64'(dut_rst_a), 64'd1);
      chk({tag, " a running"}, 64'(running_a), 64'd0);
      chk({tag, " a finish"}, 64'(finish_a), 64'd0);
      chk({tag, " a done"}, 64'(done_a), 64'd0);
      chk({tag, " a status"}, 64'(status_a), 64'd0);
      chk({tag, " a cycles"}, 64'(cycles_a), 64'd0);
      chk({tag, " a mask"}, 64'(mask_a), 64'd0);
      chk({tag, " b dut_rst"}, 64'(dut_rst_b), 64'd1);
      chk({tag, " b running"}, 64'(running_b), 64'd0);
      chk({tag, " b done"}, 64'(done_b), 64'd0);
      chk({tag, " b status"}, 64'(status_b), 64'd0);
      chk({tag, " b cycles"}, 64'(cycles_b), 64'd0);
      chk({tag, " b mask"}, 64'(mask_b), 64'd0);
   endtask

   task automatic build(input int r);
      int kind, e, z;
      for (int c = 0; c < LEN; c++) begin
         halt_v[c] = '0;
         commit_v[c] = 8'h01;
         mon_v[c] = 1'b0;
         mem_v[c] = 1'b0;
      end
      case (r)
         0: halt_v[100] = 8'h04;
         1: for (int i = 0; i < CH; i++) halt_v[8 + 6 * i][i] = 1'b1;
         2: for (int c = 0; c < LEN; c++) commit_v[c] = (c % 2 == 1) ? 8'h01 : 8'h00;
         3: for (int c = 0; c < LEN; c++) commit_v[c] = (c <= 20) ? 8'h10 : 8'h00;
         4: begin
            halt_v[30] = 8'h01;
            mon_v[30] = 1'b1;
            mem_v[35] = 1'b1;
         end
         5: mem_v[60] = 1'b1;
         6: mon_v[40] = 1'b1;
         default: begin
            kind = $urandom_range(0, 2);
            for (int c = 0; c < LEN; c++)
               commit_v[c] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (kind == 0) begin
               for (int c = 0; c < LEN; c++)
                  for (int b = 0; b < CH; b++) halt_v[c][b] = ($urandom_range(0, 63) == 0);
            end else if (kind == 1) begin
               e = $urandom_range(0, 300);
               mon_v[e] = ($urandom_range(0, 1) == 1);
               mem_v[e] = !mon_v[e] || ($urandom_range(0, 1) == 1);
               halt_v[e] = 8'($urandom);
               for (int k = 1; k <= 20; k++) begin
                  mem_v[e + k] = ($urandom_range(0, 7) == 0);
                  mon_v[e + k] = ($urandom_range(0, 7) == 0);
                  halt_v[e + k] = 8'($urandom);
               end
            end else begin
               z = $urandom_range(0, 500);
               for (int c = z; c < LEN; c++) commit_v[c] = 8'h00;
            end
         end
      endcase
   endtask

   task automatic do_run(input int abort_at);
      bit aborted;
      aborted = 0;
      rst = 1'b1;
      cur_c = -1;
      halt = 8'($urandom);
      commit = 8'($urandom);
      mon_error = 1'b1;
      mem_error = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk("a dut_rst edge1", 64'(dut_rst_a), 64'd1);
      chk("a running edge1", 64'(running_a), 64'd0);
      chk("b dut_rst edge1", 64'(dut_rst_b), 64'd1);
      @(posedge clk);
      #1;
      chk("a dut_rst edge2", 64'(dut_rst_a), 64'd0);
      chk("a running edge2", 64'(running_a), 64'd1);
      chk("a cycles at run start", 64'(cycles_a), 64'd0);
      chk("b running edge2", 64'(running_b), 64'd1);
      for (int c = 0; c < LEN; c++) begin
         cur_c = c;
         halt = halt_v[c];
         commit = commit_v[c];
         mon_error = mon_v[c];
         mem_error = mem_v[c];
         if (c == abort_at) begin
            #2 rst = 1'b1;
            #1 chk_reset("async reset in drain");
            q0.delete();
            q1.delete();
            cur_c = -1;
            aborted = 1;
            break;
         end
         @(posedge clk);
         #1;
         cur_c = c + 1;
         if (done_a && done_b) break;
      end
      halt = '0;
      commit = '0;
      mon_error = 1'b0;
      mem_error = 1'b0;
      if (!aborted) begin
         @(posedge clk);
         #1;
         chk("a pending expectations", 64'(q0.size()), 64'd0);
         chk("b pending expectations", 64'(q1.size()), 64'd0);
         q0.delete();
         q1.delete();
         chk("a finish after done", 64'(finish_a), 64'd0);
         chk("a done held", 64'(done_a), 64'd1);
         chk("b finish after done", 64'(finish_b), 64'd0);
         chk("b done held", 64'(done_b), 64'd1);
      end
   endtask

   initial begin
      for (int r = 0; r < RUNS; r++) begin
         build(r);
         q0.push_back(model(1'b0, 16));
         q1.push_back(model(1'b1, 0));
         do_run((r == 6) ? 45 : -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
